hsync_detector: RTL
===================

# hsync_detector

Receive-side counterpart to the horizontal sync generator. Consumes a one-cycle horizontal sync pulse stream, measures the line period, declares lock after a run of consecutive correct lines, and supplies the current horizontal pixel position to downstream overlay logic. Sits between the sync source (generator or external video input) and the pixel-compositing path.

## Interface
- busWidth, 11, width of all pixel counters and length outputs
- resHorizontal, 1920, expected count value at each sync pulse; must be < 2^busWidth - 1
- lockCount, 4, consecutive matching lines required to enter LOCKED; range 1..15
- clock  in  1  system pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- hSyncIn  in  1  one-cycle-high horizontal sync pulse
- pixelX  out  busWidth  cycles since last accepted sync, saturating
- lineLength  out  busWidth  count captured at most recent sync pulse
- locked  out  1  high while in LOCKED state
- lineStart  out  1  one-cycle pulse, cycle after a sync accepted while LOCKED
- lockLost  out  1  one-cycle pulse on exit from LOCKED
- vSyncIn  in  1  (VCOUNT_EN only) one-cycle-high vertical sync pulse
- pixelY  out  busWidth  (VCOUNT_EN only) line index since last vSyncIn, saturating

## Operation
- States: SEARCH, MEASURE, LOCKED.
- hCount: on hSyncIn=1, lineLength <= hCount and hCount <= 0; otherwise hCount <= hCount + 1, saturating at 2^busWidth - 1. pixelX = hCount.
- A generator pulsing every resHorizontal+1 cycles yields lineLength = resHorizontal.
- SEARCH: hCount runs but is ignored. First hSyncIn -> MEASURE, matchCnt <= 0.
- MEASURE: on hSyncIn, match = (hCount == resHorizontal).
  - Match: matchCnt + 1. If this reaches lockCount -> LOCKED.
  - Mismatch: matchCnt <= 0; stay in MEASURE.
- LOCKED: on hSyncIn with match, assert lineStart next cycle; stay.
  - hSyncIn with mismatch (early pulse) -> MEASURE, matchCnt <= 0, lockLost pulse.
  - hCount == resHorizontal + 1 with no hSyncIn (missing pulse) -> MEASURE immediately, matchCnt <= 0, lockLost pulse.
- hSyncIn held high for several cycles: each high cycle is treated as a pulse, so the second high cycle captures 0 -> mismatch.
- Saturated hCount never wraps. A later pulse then captures all-ones, which is always a mismatch.

## Timing
- All outputs are registered; 1-cycle latency from the hSyncIn edge to lineLength/pixelX/locked/lineStart/lockLost updates.
- lockLost and the locked falling edge appear in the same cycle.
- With lockCount = N and a clean source, locked rises 1 cycle after the (N+1)-th pulse (first pulse only starts measurement).
- Reset (any cycle, including mid-line or while LOCKED): state SEARCH, hCount = 0, matchCnt = 0, pixelX = 0, lineLength = 0, locked = 0, lineStart = 0, lockLost = 0, pixelY = 0. No lockLost pulse is generated by reset.
- hSyncIn in the same cycle as reset is ignored.

## Configuration
- VCOUNT_EN defined:
  - vSyncIn and pixelY ports exist.
  - vCount increments on each accepted hSyncIn while LOCKED and saturates.
  - vSyncIn resets vCount to 0. If vSyncIn and hSyncIn are high in the same cycle, vSyncIn wins and the result is 0.
  - vCount is held at 0 when not LOCKED.
- VCOUNT_EN undefined: ports absent, no vertical logic; horizontal behaviour is identical.

## Structure
- Shared package video_timing_pkg: state enum (SEARCH, MEASURE, LOCKED), default resolution constants (1920, 1080), default busWidth.
- One sub-module, sat_counter: parameterised width, sync clear, enable, saturate at all-ones. Instantiated for hCount and (under VCOUNT_EN) vCount.

## Test plan
- Clean source, pulse every 1921 cycles, lockCount 4: locked rises 1 cycle after the 5th pulse; lineLength = 1920; lineStart pulses every 1921 cycles thereafter.
- Locked, then one pulse arrives at hCount = 1000: lineLength = 1000, lockLost pulse, locked = 0; relock after 4 further clean lines.
- Locked, then one pulse omitted: lockLost asserts 1 cycle after hCount reaches 1921; pixelX keeps counting to 2047 and holds there.
- Reset asserted mid-line while LOCKED: next cycle all outputs are 0 and state is SEARCH; the first following pulse does not count toward matchCnt.
- MEASURE with lines 1920, 1920, 1919, 1920×4: no lock until the 4th match after the 1919 line.
- VCOUNT_EN, locked: 3 lines give pixelY = 3; vSyncIn coincident with hSyncIn gives pixelY = 0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared video timing types and default resolution constants.
package video_timing_pkg;

  // Sync detector lock state.
  typedef enum logic [1:0] {
    StSearch,
    StMeasure,
    StLocked
  } det_state_e;

  localparam int unsigned DefResH      = 1920;
  localparam int unsigned DefResV      = 1080;
  localparam int unsigned DefBusWidth  = 11;
  localparam int unsigned DefLockCount = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned width = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [width-1:0] count
);

  // Clear has priority over counting; saturate at all-ones.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + width'(1);
    end
  end

endmodule

// File: rtl/hsync_detector.sv
// Horizontal sync detector: measures line period, locks after a run of correct lines and
// reports the current pixel position. Define VCOUNT_EN to add vertical line counting
// (vSyncIn / pixelY).
module hsync_detector
  import video_timing_pkg::*;
#(
  parameter int unsigned busWidth      = DefBusWidth,
  parameter int unsigned resHorizontal = DefResH,
  parameter int unsigned lockCount     = DefLockCount
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hSyncIn,
  output logic [busWidth-1:0] pixelX,
  output logic [busWidth-1:0] lineLength,
  output logic                locked,
  output logic                lineStart,
  output logic                lockLost
`ifdef VCOUNT_EN
  ,
  input  logic                vSyncIn,
  output logic [busWidth-1:0] pixelY
`endif
);

  localparam logic [busWidth-1:0] ResH       = busWidth'(resHorizontal);
  // First count value at which a locked line is known to have lost its pulse.
  localparam logic [busWidth-1:0] ResHMissed = busWidth'(resHorizontal + 1);
  localparam logic [3:0]          LockTarget = 4'(lockCount);

  det_state_e          state_q, state_d;
  logic [3:0]          match_cnt_q, match_cnt_d;
  logic [busWidth-1:0] hcount;
  logic                hcount_match;
  logic                line_start_d, lock_lost_d;

  // Every high cycle of hSyncIn restarts the line count.
  sat_counter #(
    .width(busWidth)
  ) u_hcount (
    .clock (clock),
    .reset (reset),
    .clear (hSyncIn),
    .enable(1'b1),
    .count (hcount)
  );

  assign hcount_match = (hcount == ResH);
  assign pixelX       = hcount;
  assign locked       = (state_q == StLocked);

  // Lock FSM next-state and pulse decode.
  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    line_start_d = 1'b0;
    lock_lost_d  = 1'b0;
    unique case (state_q)
      StSearch: begin
        // First pulse only establishes a line origin.
        if (hSyncIn) begin
          state_d     = StMeasure;
          match_cnt_d = '0;
        end
      end
      StMeasure: begin
        if (hSyncIn) begin
          if (hcount_match) begin
            if ((match_cnt_q + 4'd1) == LockTarget) begin
              state_d     = StLocked;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 4'd1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
      end
      StLocked: begin
        if (hSyncIn) begin
          if (hcount_match) begin
            line_start_d = 1'b1;
          end else begin
            state_d     = StMeasure;
            match_cnt_d = '0;
            lock_lost_d = 1'b1;
          end
        end else if (hcount == ResHMissed) begin
          state_d     = StMeasure;
          match_cnt_d = '0;
          lock_lost_d = 1'b1;
        end
      end
      default: begin
        state_d     = StSearch;
        match_cnt_d = '0;
      end
    endcase
  end

  // State, captured line length and registered pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StSearch;
      match_cnt_q <= '0;
      lineLength  <= '0;
      lineStart   <= 1'b0;
      lockLost    <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      lineStart   <= line_start_d;
      lockLost    <= lock_lost_d;
      if (hSyncIn) begin
        lineLength <= hcount;
      end
    end
  end

`ifdef VCOUNT_EN
  logic vcount_clear, vcount_inc;

  // Held at zero whenever the next state is not LOCKED; vSyncIn beats a coincident hSyncIn.
  assign vcount_clear = vSyncIn || (state_d != StLocked);
  assign vcount_inc   = (state_q == StLocked) && hSyncIn && hcount_match;

  sat_counter #(
    .width(busWidth)
  ) u_vcount (
    .clock (clock),
    .reset (reset),
    .clear (vcount_clear),
    .enable(vcount_inc),
    .count (pixelY)
  );
`endif

endmodule
